updi_start_ctrl: RTL

//   Front-panel trigger stage directly upstream of the UPDI programmer. It synchronises and

---
 rtl/updi_start_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/updi_start_ctrl.sv
// Debounced push-button start control for a UPDI programmer, with run/done/error status LEDs.
// Latency: btn_raw rise -> press after 2 + DEBOUNCE_CYCLES edges; start follows one edge later.
// No backpressure: a press seen while a run is starting or active is dropped, never queued.
module updi_start_ctrl #(
  parameter int DEBOUNCE_CYCLES     = 100000,
  parameter int BUSY_TIMEOUT_CYCLES = 1000,
  parameter int BLINK_DIV           = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic prog_busy,
  output logic start,
  output logic led_run,
  output logic led_done,
  output logic led_error
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX    = '1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(BUSY_TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } state_t;

  logic          sync1;
  logic          btn_s;
  logic          btn_stable;
  logic [DW-1:0] deb_cnt;
  logic          press;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_nxt;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_nxt;
  logic          err_nxt;

  // Synchronise the raw button, debounce it, and emit press on an accepted 0->1 change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1      <= 1'b0;
      btn_s      <= 1'b0;
      btn_stable <= 1'b0;
      deb_cnt    <= '0;
      press      <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
      press <= 1'b0;
      if (btn_s == btn_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        // Press is registered alongside btn_stable, so it lines up with the rising edge.
        btn_stable <= btn_s;
        deb_cnt    <= '0;
        press      <= btn_s;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Next-state, timeout counter and blink phase; outputs are derived from the next state.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    blink_nxt = blink_cnt;
    err_nxt   = led_error;
    case (state)
      ST_IDLE: begin
        // A busy line that is already high here is ignored; only a press starts a run.
        if (press) state_nxt = ST_START;
      end
      ST_START: begin
        tmo_nxt   = '0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Busy wins over the final timeout count.
        if (prog_busy) begin
          state_nxt = ST_RUN;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_ERROR;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        // Any drop of busy ends the run; glitches are not filtered.
        if (!prog_busy) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (press) state_nxt = ST_START;
      end
      ST_ERROR: begin
        if (press) begin
          state_nxt = ST_START;
        end else if (blink_cnt == BLINK_LAST) begin
          blink_nxt = '0;
          err_nxt   = ~led_error;
        end else begin
          blink_nxt = blink_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The blink starts high with a fresh phase on entry, and is dark outside ERROR.
    if (state_nxt == ST_ERROR && state != ST_ERROR) begin
      err_nxt   = 1'b1;
      blink_nxt = '0;
    end else if (state_nxt != ST_ERROR) begin
      err_nxt   = 1'b0;
      blink_nxt = '0;
    end
  end

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      blink_cnt <= '0;
      start     <= 1'b0;
      led_run   <= 1'b0;
      led_done  <= 1'b0;
      led_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmo_cnt   <= tmo_nxt;
      blink_cnt <= blink_nxt;
      start     <= (state_nxt == ST_START);
      led_run   <= (state_nxt == ST_WAIT) || (state_nxt == ST_RUN);
      led_done  <= (state_nxt == ST_DONE);
      led_error <= err_nxt;
    end
  end

endmodule
